// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared MVM result geometry and types
package mvm_pkg;
  localparam int OWIDTH     = 32;
  localparam int NUM_OLANES = 8;
  localparam int LANE_W     = $clog2(NUM_OLANES);

  typedef logic signed [OWIDTH-1:0] result_burst_t [0:NUM_OLANES-1];
  typedef logic [LANE_W-1:0] lane_idx_t;
endpackage

// File: rtl/burst_ring.sv
// rtl/burst_ring.sv - ring of whole result bursts with occupancy count
module burst_ring
  import mvm_pkg::*;
#(
  parameter int W     = OWIDTH,
  parameter int LANES = NUM_OLANES,
  parameter int NBUF  = 2,
  localparam int PW   = $clog2(NBUF),
  localparam int CW   = PW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic signed [W-1:0] i_data [0:LANES-1],
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [CW-1:0]       o_count,
  output logic signed [W-1:0] o_head [0:LANES-1]
);
  logic signed [W-1:0] r_mem [0:NBUF-1][0:LANES-1];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(NBUF));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/mvm_result_drain.sv
// rtl/mvm_result_drain.sv - buffers MVM result bursts and streams them one lane per beat
module mvm_result_drain #(
  parameter int OWIDTH     = mvm_pkg::OWIDTH,
  parameter int NUM_OLANES = mvm_pkg::NUM_OLANES,
  parameter int NUM_BUFS   = 2,
  localparam int LW        = $clog2(NUM_OLANES),
  localparam int CW        = $clog2(NUM_BUFS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [OWIDTH-1:0] i_result [0:NUM_OLANES-1],
  input  logic                     i_valid,
  output logic [OWIDTH-1:0]        o_tdata,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic                     o_tlast,
  output logic [LW-1:0]            o_tlane,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow,
  output logic [CW-1:0]            o_count,
  output logic                     o_busy
);
  logic signed [OWIDTH-1:0] w_head [0:NUM_OLANES-1];
  logic                     w_full;
  logic                     w_empty;
  logic                     w_xfer;
  logic                     w_free;
  logic                     w_space;
  logic                     w_push;
  logic                     w_drop;
  logic [LW-1:0]            r_lane;
  logic                     r_overflow;

  // A burst finishing this edge frees a slot for a burst arriving the same edge.
  assign w_xfer  = o_tvalid & i_tready;
  assign w_free  = w_xfer & o_tlast;
  assign w_space = ~w_full | w_free;
  assign w_push  = i_valid & w_space;
  assign w_drop  = i_valid & ~w_space;

  burst_ring #(
    .W     (OWIDTH),
    .LANES (NUM_OLANES),
    .NBUF  (NUM_BUFS)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (i_result),
    .i_pop   (w_free),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_xfer) r_lane <= o_tlast ? '0 : r_lane + 1'b1;
      if (w_drop)              r_overflow <= 1'b1;
      else if (i_clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign o_tvalid   = ~w_empty;
  assign o_busy     = ~w_empty;
  assign o_tdata    = w_head[r_lane];
  assign o_tlane    = r_lane;
  assign o_tlast    = ~w_empty & (r_lane == LW'(NUM_OLANES - 1));
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_mvm_result_drain.sv
// tb/tb_mvm_result_drain.sv - vector table, directed corners and random run against a queue model
module tb_mvm_result_drain;
  import mvm_pkg::*;

  localparam int NB = 2;
  localparam int N  = NUM_OLANES;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [OWIDTH-1:0] i_result [0:N-1];
  logic                     i_valid;
  logic [OWIDTH-1:0]        o_tdata;
  logic                     o_tvalid;
  logic                     i_tready;
  logic                     o_tlast;
  logic [LANE_W-1:0]        o_tlane;
  logic                     o_overflow;
  logic                     i_clr_overflow;
  logic [1:0]               o_count;
  logic                     o_busy;

  mvm_result_drain #(.OWIDTH(OWIDTH), .NUM_OLANES(N), .NUM_BUFS(NB)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
    .o_tlane(o_tlane), .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow),
    .o_count(o_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  result_burst_t m_q[$];
  int            m_lane;
  bit            m_ovf;
  bit            m_known;
  int            n_vec;
  int            n_err;

  typedef struct {
    bit r; bit v; int l0; bit tr; bit clr;
    bit e_tvalid; int e_count; bit e_ovf; int e_tlane; bit e_tlast;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic result_burst_t mk(input int l0);
    result_burst_t b;
    for (int i = 0; i < N; i++) b[i] = (i == 0) ? l0 : l0 * 16 + i;
    return b;
  endfunction

  task automatic model_check();
    if (!m_known) return;
    chk("m_tvalid", int'(o_tvalid), int'(m_q.size() != 0));
    chk("m_count", int'(o_count), m_q.size());
    chk("m_busy", int'(o_busy), int'(m_q.size() != 0));
    chk("m_ovf", int'(o_overflow), int'(m_ovf));
    if (m_q.size() != 0) begin
      chk("m_tdata", int'(o_tdata), int'(m_q[0][m_lane]));
      chk("m_tlane", int'(o_tlane), m_lane);
      chk("m_tlast", int'(o_tlast), int'(m_lane == N - 1));
    end
  endtask

  // Check the model against the DUT, apply one cycle of inputs, advance both by one edge.
  task automatic cycle(input bit r, input bit v, input result_burst_t b, input bit tr, input bit clr);
    bit xfer, fin, space;
    model_check();
    rst = r; i_valid = v; i_result = b; i_tready = tr; i_clr_overflow = clr;
    if (r) begin
      m_q.delete(); m_lane = 0; m_ovf = 0;
    end else begin
      xfer  = (m_q.size() != 0) && tr;
      fin   = xfer && (m_lane == N - 1);
      space = (m_q.size() < NB) || fin;
      if (xfer) begin
        if (fin) begin m_lane = 0; void'(m_q.pop_front()); end
        else m_lane++;
      end
      if (v && space) m_q.push_back(b);
      if (v && !space) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    @(posedge clk);
    @(negedge clk);
    m_known = 1;
  endtask

  result_burst_t t1, z;
  vec_t          tbl[0:7];
  int            got[$];
  int            has3;
  int            k;
  bit            tr;

  initial begin
    n_vec = 0; n_err = 0; m_known = 0; m_lane = 0; m_ovf = 0;
    z = mk(0);
    rst = 1; i_valid = 0; i_result = z; i_tready = 0; i_clr_overflow = 0;
    t1 = '{-5, 100, 0, 32'sh7fffffff, 32'sh80000000, 7, -1, 42};
    @(negedge clk);
    cycle(1, 0, z, 0, 0);

    // single burst, always ready
    cycle(0, 1, t1, 1, 0);
    for (int i = 0; i < N; i++) begin
      chk("t1_tvalid", int'(o_tvalid), 1);
      chk("t1_data", int'(o_tdata), int'(t1[i]));
      chk("t1_lane", int'(o_tlane), i);
      chk("t1_last", int'(o_tlast), int'(i == N - 1));
      cycle(0, 0, z, 1, 0);
    end
    chk("t1_idle_tvalid", int'(o_tvalid), 0);
    chk("t1_idle_count", int'(o_count), 0);

    // backpressure 1,0,0 repeating
    cycle(0, 1, t1, 0, 0);
    got.delete();
    k = 0;
    while (k < 60 && got.size() < N) begin
      tr = (k % 3 == 0);
      if (o_tvalid && tr) got.push_back(int'(o_tdata));
      cycle(0, 0, z, tr, 0);
      k++;
    end
    chk("t2_beats", got.size(), N);
    for (int i = 0; i < got.size(); i++) chk("t2_order", got[i], int'(t1[i]));
    chk("t2_idle_tvalid", int'(o_tvalid), 0);

    // fill, overflow, and clear-vs-drop collision
    tbl[0] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0,   1, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 2, 0, 0,   1, 2, 0, 0, 0};
    tbl[3] = '{0, 1, 3, 0, 0,   1, 2, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0};
    tbl[5] = '{0, 1, 4, 0, 1,   1, 2, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0,   1, 2, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].v, mk(tbl[i].l0), tbl[i].tr, tbl[i].clr);
      chk($sformatf("tbl%0d_tvalid", i), int'(o_tvalid), int'(tbl[i].e_tvalid));
      chk($sformatf("tbl%0d_count", i), int'(o_count), tbl[i].e_count);
      chk($sformatf("tbl%0d_ovf", i), int'(o_overflow), int'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_tlane", i), int'(o_tlane), tbl[i].e_tlane);
      chk($sformatf("tbl%0d_tlast", i), int'(o_tlast), int'(tbl[i].e_tlast));
    end
    got.delete();
    for (int i = 0; i < 2 * N; i++) begin
      if (o_tvalid) got.push_back(int'(o_tdata));
      cycle(0, 0, z, 1, 0);
    end
    has3 = 0;
    foreach (got[i]) if (got[i] == 3) has3 = 1;
    chk("t3_beats", got.size(), 2 * N);
    if (got.size() == 2 * N) begin
      chk("t3_first", got[0], 1);
      chk("t3_second", got[N], 2);
    end
    chk("t3_no3", has3, 0);
    chk("t3_empty", int'(o_count), 0);

    // free and capture on the same edge while full
    cycle(0, 1, mk(5), 0, 0);
    cycle(0, 1, mk(6), 0, 0);
    for (int i = 0; i < N - 1; i++) cycle(0, 0, z, 1, 0);
    chk("t4_last_pending", int'(o_tlast), 1);
    cycle(0, 1, mk(9), 1, 0);
    chk("t4_ovf", int'(o_overflow), 0);
    chk("t4_count", int'(o_count), 2);
    got.delete();
    k = 0;
    while (k < 40 && o_tvalid) begin
      if (o_tlane == 0) got.push_back(int'(o_tdata));
      cycle(0, 0, z, 1, 0);
      k++;
    end
    chk("t4_bursts", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_b0", got[0], 6);
      chk("t4_b1", got[1], 9);
    end

    // reset in the middle of a burst, with overflow set
    cycle(0, 1, mk(20), 0, 0);
    cycle(0, 1, mk(21), 0, 0);
    cycle(0, 1, mk(22), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, z, 1, 0);
    cycle(1, 0, z, 1, 0);
    chk("t5_tvalid", int'(o_tvalid), 0);
    chk("t5_count", int'(o_count), 0);
    chk("t5_ovf", int'(o_overflow), 0);
    cycle(0, 0, z, 1, 0);
    chk("t5_quiet", int'(o_tvalid), 0);
    cycle(0, 1, mk(11), 1, 0);
    chk("t5_new_tvalid", int'(o_tvalid), 1);
    chk("t5_new_lane", int'(o_tlane), 0);
    chk("t5_new_data", int'(o_tdata), 11);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      result_burst_t rb;
      for (int j = 0; j < N; j++) rb[j] = $urandom;
      cycle(($urandom % 400) == 0, ($urandom % 5) == 0, rb,
            (i % 200 < 100) ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
            ($urandom % 20) == 0);
    end
    for (int i = 0; i < 3 * N; i++) cycle(0, 0, z, 1, 0);
    model_check();
    chk("final_empty", int'(o_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mvm_result_drain.md
Name: mvm_result_drain

Overview:
- Hardware consumer for the MVM result port: captures each NUM_OLANES-wide result burst presented on the MVM o_result/o_valid outputs and serializes it, one lane per beat, onto a valid/ready stream.
- The MVM has no backpressure, so the block holds a small ring of burst buffers and flags dropped bursts.
- Sits between mvm and any downstream sink (DMA, UART bridge, checker).

Parameters:
- OWIDTH, 32, width of one signed result lane.
- NUM_OLANES, 8, lanes per MVM result burst.
- NUM_BUFS, 2, number of burst buffers; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- i_result  input  OWIDTH x [0:NUM_OLANES-1]  signed MVM result lanes.
- i_valid  input  1  MVM o_valid; one-cycle pulse per burst.
- o_tdata  output  OWIDTH  current lane value.
- o_tvalid  output  1  o_tdata valid.
- i_tready  input  1  downstream accepts beat.
- o_tlast  output  1  high on lane NUM_OLANES-1 of a burst.
- o_tlane  output  $clog2(NUM_OLANES)  lane index of the current beat.
- o_overflow  output  1  sticky: a burst was dropped.
- i_clr_overflow  input  1  clears o_overflow.
- o_count  output  $clog2(NUM_BUFS)+1  number of occupied buffers.
- o_busy  output  1  o_count != 0.

Behaviour:
- Reset (synchronous, active-high): write pointer, read pointer, lane counter, o_count and o_overflow go to 0; o_tvalid, o_tlast and o_busy go to 0; o_tlane is 0; o_tdata is don't-care while o_tvalid=0. Buffer contents are not reset.
- Reset mid-burst: all buffered data is discarded. No beat is emitted after reset until a new i_valid arrives.
- Capture: an i_valid sampled at edge k with space available stores all lanes into buf[wptr] and increments wptr modulo NUM_BUFS.
- Space available means o_count < NUM_BUFS, or the current beat is the final beat of a burst (o_tvalid & i_tready & o_tlast) at the same edge.
- Latency: with o_count=0, an i_valid at edge k gives o_tvalid=1 with lane 0 valid after edge k (cycle k+1).
- Stream output:
  - o_tvalid = (o_count != 0).
  - o_tdata = buf[rptr][lane]; o_tlane = lane; o_tlast = (lane == NUM_OLANES-1).
  - Outputs are driven from registers through a mux only; no combinational path from i_tready to o_tvalid.
- Handshake: a beat transfers when o_tvalid & i_tready at a clock edge.
  - Lane increments on each transfer.
  - On the last lane, lane returns to 0 and rptr increments modulo NUM_BUFS, which frees the buffer.
  - o_tdata, o_tlane and o_tlast hold stable while o_tvalid=1 & i_tready=0.
- o_count update per edge: +1 on capture, -1 on free, unchanged if both or neither occur.
- Full boundary: i_valid with o_count=NUM_BUFS and no free at the same edge means the burst is dropped. Buffers and pointers are unchanged, and o_overflow is set the next cycle.
- If i_valid and a free coincide when full, the burst is accepted and o_count stays at NUM_BUFS.
- Overflow clear: i_clr_overflow clears o_overflow. A simultaneous drop takes priority (o_overflow stays 1).
- Values pass through unmodified (signed, full OWIDTH); no arithmetic is performed on data.
- Pointer wrap: wptr and rptr wrap NUM_BUFS-1 to 0. Full and empty are distinguished by o_count, not by pointer equality.

Decomposition:
- Shared package mvm_pkg:
  - localparams OWIDTH and NUM_OLANES, shared with mvm.
  - typedef result_burst_t: unpacked array [0:NUM_OLANES-1] of logic signed [OWIDTH-1:0].
  - typedef lane_idx_t.
- One sub-module, burst_ring: NUM_BUFS x result_burst_t storage with wptr, rptr and count, exposing push/pop/full/empty and a head burst.
- mvm_result_drain holds the lane counter, the output mux and the overflow logic.

Test Plan:
1. Single burst, i_tready=1 always. Inject lanes 0..7 = {-5, 100, 0, 2147483647, -2147483648, 7, -1, 42} at edge k. Expect o_tvalid at cycles k+1..k+8 emitting those values in order, o_tlane 0..7, o_tlast only on 42; then o_tvalid=0 and o_count=0.
2. Backpressure: same burst with i_tready toggling 1,0,0,1,... Expect exactly 8 transfers, in order, with o_tdata stable during stalls and no duplicated or skipped lanes.
3. Fill and overflow, NUM_BUFS=2, i_tready=0. Three i_valid pulses with lane 0 = 1, 2, 3. Expect o_count=2 and o_overflow=1 after the third pulse. Then i_tready=1: 16 beats come out with lane 0 = 1 then 2, and value 3 never appears. Pulsing i_clr_overflow then gives o_overflow=0.
4. Simultaneous free and capture: hold full, assert i_tready so the last beat of buf0 transfers on the same edge as a new i_valid (lane 0 = 9). Expect no overflow, o_count remains 2, and 9 is emitted after the second burst.
5. Reset mid-burst: assert rst after 3 beats of a burst. Expect o_tvalid=0, o_count=0, o_overflow=0 next cycle. A following burst with lane 0 = 11 emits starting at o_tlane=0.
6. Clear vs drop collision: assert i_clr_overflow on the same edge as a dropped burst. Expect o_overflow=1.
